// File: rtl/shift_pkg.sv
// Shared constants and types for the sequential MIPS shift unit:
// funct encodings, FSM state codes, the decoded shift op and its decoder.
package shift_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SHW   = 5;

   localparam logic [5:0] FUNCT_SLL = 6'b000000;
   localparam logic [5:0] FUNCT_SRL = 6'b000010;
   localparam logic [5:0] FUNCT_SRA = 6'b000011;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   // The funct field is decoded once at accept time, so only two bits of op are stored.
   typedef enum logic [1:0] {
      OP_SLL = 2'd0,
      OP_SRL = 2'd1,
      OP_SRA = 2'd2,
      OP_ILL = 2'd3
   } op_e;

   function automatic op_e decode_funct(input logic [5:0] f);
      op_e op;
      case (f)
         FUNCT_SLL: op = OP_SLL;
         FUNCT_SRL: op = OP_SRL;
         FUNCT_SRA: op = OP_SRA;
         default:   op = OP_ILL;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/shift_seq_unit_shift1_step.sv
// Single-bit shift of the accumulator by the decoded op; purely combinational.
// An illegal op leaves the value untouched.
module shift1_step
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] acc_i,
   input  op_e              op_i,
   output logic [WIDTH-1:0] acc_o
);

   always_comb begin
      acc_o = acc_i;
      case (op_i)
         OP_SLL:  acc_o = {acc_i[WIDTH-2:0], 1'b0};
         OP_SRL:  acc_o = {1'b0, acc_i[WIDTH-1:1]};
         OP_SRA:  acc_o = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
         default: acc_o = acc_i;
      endcase
   end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle sll/srl/sra unit: one bit position per clock under a start/busy/done
// handshake. start is honoured only in IDLE or DONE; busy and done never overlap.
module shift_seq_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SHW   = DEF_SHW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] rt,
   input  logic [SHW-1:0]   shamt,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] rd,
   output logic [1:0]       dbg_state
);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   op_e              op_q, op_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] rd_q, rd_d;

   logic [WIDTH-1:0] acc_step;
   op_e              op_in;
   logic             op_in_ill;

   assign op_in     = decode_funct(funct);
   assign op_in_ill = (op_in == OP_ILL);

   shift1_step #(.WIDTH(WIDTH)) u_step (
      .acc_i (acc_q),
      .op_i  (op_q),
      .acc_o (acc_step)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      err_d   = err_q;
      rd_d    = rd_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               acc_d   = rt;
               // Illegal ops skip straight to DONE after a single SHIFT cycle.
               cnt_d   = op_in_ill ? '0 : shamt;
               op_d    = op_in;
               err_d   = op_in_ill;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_q != '0) begin
               acc_d = acc_step;
               cnt_d = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
            end else begin
               rd_d    = err_q ? '0 : acc_q;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         op_q    <= OP_SLL;
         err_q   <= 1'b0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
      end
   end

   assign busy      = (state_q == SHIFT);
   assign done      = (state_q == DONE);
   assign err       = (state_q == DONE) && err_q;
   assign rd        = rd_q;
   assign dbg_state = state_q;

endmodule

// File: doc/shift_seq_unit.md
# shift_seq_unit

Multi-cycle shift execution unit for the MIPS R-type shift group (sll, srl, sra), one bit position per clock. Sits in the execute stage beside the combinational ALU/shifter. Consumes decoded fields (rt value, shamt, funct) under a start/busy/done handshake and produces rd for the register-file write path. Used where a full barrel shifter is not wanted, and as a cycle-level cross-check of the combinational srl.

## Interface
Parameters:
- WIDTH, 32, datapath width (rt, rd)
- SHW, 5, shamt width; must satisfy 2**SHW == WIDTH

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  request; sampled on rising edge, accepted only in IDLE or DONE
- funct  input  6  MIPS funct: 6'b000000 sll, 6'b000010 srl, 6'b000011 sra; any other value is illegal
- rt  input  WIDTH  operand, captured on accept
- shamt  input  SHW  shift amount 0..31, captured on accept
- busy  output  1  high in SHIFT state
- done  output  1  one-cycle pulse, high in DONE state
- err  output  1  high with done when the accepted funct was illegal
- rd  output  WIDTH  result; valid while done is high and held until the next done

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE/DONE + start: latch acc<=rt, cnt<=shamt, op<=funct, err_r<=(funct illegal); go to SHIFT. Without start: DONE->IDLE, IDLE stays.
- SHIFT, cnt!=0, legal op: acc shifted by exactly one bit (sll: left, LSB fill 0; srl: right, MSB fill 0; sra: right, MSB fill acc[WIDTH-1]); cnt<=cnt-1.
- SHIFT, cnt==0: rd<=acc (or rd<=0 if err_r); go to DONE.
- Illegal funct: no shifting; cnt forced to 0 on accept, so DONE follows after one SHIFT cycle with rd=0, err=1.
- start while busy: ignored; no effect on acc, cnt, op.
- start during DONE: accepted (back-to-back); done still pulses for exactly that cycle.
- shamt=0: rd=rt (all ops), no shift.
- No wrap-around: cnt is SHW bits, decremented only when non-zero.
- Reset (any time, incl. mid-SHIFT): state=IDLE; busy=0, done=0, err=0, rd=0, acc=0, cnt=0; in-flight operation discarded, no done produced.

## Timing
- Accepting edge = E0. busy high from E0 to E(shamt+1). done/err high for the single cycle following edge E(shamt+1).
- Latency start-accept to done: shamt+2 edges (shamt=0 -> 2 edges; shamt=31 -> 33 edges; illegal -> 2 edges).
- busy and done never high together.
- rd changes only at the edge entering DONE (or reset); stable otherwise.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package shift_pkg: funct constants FUNCT_SLL/FUNCT_SRL/FUNCT_SRA, state enum/localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), default WIDTH/SHW.
- One sub-module: shift1_step — combinational single-bit shift of acc by op; instantiated once in the datapath. FSM, counter and output registers in shift_seq_unit.

## Test plan
- srl, rt=32'hFFFFFFFF, shamt=1 -> done 3 edges after accept, rd=32'h7FFFFFFF, err=0.
- srl, rt=32'hFFFFFFFF, shamt=31 -> busy for 32 cycles, rd=32'h00000001; shamt=3 -> rd=32'h1FFFFFFF.
- sra rt=32'h80000000 shamt=3 -> rd=32'hF0000000; sll rt=32'h00000001 shamt=31 -> rd=32'h80000000; sll shamt=0 rt=32'h12345678 -> rd=32'h12345678 after 2 edges.
- Illegal funct 6'b100000, rt=32'hFFFFFFFF -> done after 2 edges, err=1, rd=0.
- start pulsed mid-SHIFT -> ignored, first result unchanged; start during DONE -> second op accepted, correct second result.
- reset asserted at cycle 5 of a shamt=20 srl -> outputs 0 immediately (no clock edge needed), no done; new op after release completes correctly.
